// File: rtl/inert_sensor_reader_if.sv
// rtl/inert_sensor_reader_if.sv - snd/cmd/done/resp handshake between sensor reader and SPI master
interface inert_sensor_reader_if;
  logic        snd;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;

  modport master (output snd, output cmd, input done, input resp);
  modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/inert_sensor_reader.sv
// rtl/inert_sensor_reader.sv - configures inertial sensor then reads pitch rate and Z accel per INT
module inert_sensor_reader #(
  parameter int PWRUP_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         INT,
  inert_sensor_reader_if.master        spi,
  output logic [15:0]                  ptch_rt,
  output logic [15:0]                  AZ,
  output logic                         vld
);

  typedef enum logic [3:0] {
    PWRUP, CFG0, CFG1, CFG2, CFG3, IDLE, RD_PL, RD_PH, RD_AZL, RD_AZH
  } state_t;

  state_t                state;
  logic [PWRUP_BITS-1:0] pwrup_cnt;
  logic                  int_ff1;
  logic                  int_ff2;
  logic [7:0]            pl_byte;
  logic [7:0]            azl_byte;
  logic                  xfer_done;
  logic                  unused_resp_hi;

  // done coinciding with snd is illegal from the master, so it is never taken as completion
  assign xfer_done      = spi.done && !spi.snd;
  assign unused_resp_hi = ^spi.resp[15:8];

  // snd and cmd are launched on the edge that enters each CFG/RD state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= PWRUP;
      pwrup_cnt <= '0;
      int_ff1   <= 1'b0;
      int_ff2   <= 1'b0;
      pl_byte   <= 8'h00;
      azl_byte  <= 8'h00;
      spi.snd   <= 1'b0;
      spi.cmd   <= 16'h0000;
      ptch_rt   <= 16'h0000;
      AZ        <= 16'h0000;
      vld       <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
      spi.snd <= 1'b0;
      vld     <= 1'b0;
      unique case (state)
        PWRUP: begin
          pwrup_cnt <= pwrup_cnt + 1'b1;
          if (&pwrup_cnt) begin
            state   <= CFG0;
            spi.snd <= 1'b1;
            spi.cmd <= 16'h0D02;
          end
        end
        CFG0: if (xfer_done) begin
          state   <= CFG1;
          spi.snd <= 1'b1;
          spi.cmd <= 16'h1053;
        end
        CFG1: if (xfer_done) begin
          state   <= CFG2;
          spi.snd <= 1'b1;
          spi.cmd <= 16'h1150;
        end
        CFG2: if (xfer_done) begin
          state   <= CFG3;
          spi.snd <= 1'b1;
          spi.cmd <= 16'h1460;
        end
        CFG3: if (xfer_done) begin
          state <= IDLE;
        end
        IDLE: if (int_ff2) begin
          state   <= RD_PL;
          spi.snd <= 1'b1;
          spi.cmd <= 16'hA200;
        end
        RD_PL: if (xfer_done) begin
          pl_byte <= spi.resp[7:0];
          state   <= RD_PH;
          spi.snd <= 1'b1;
          spi.cmd <= 16'hA300;
        end
        RD_PH: if (xfer_done) begin
          ptch_rt <= {spi.resp[7:0], pl_byte};
          state   <= RD_AZL;
          spi.snd <= 1'b1;
          spi.cmd <= 16'hAC00;
        end
        RD_AZL: if (xfer_done) begin
          azl_byte <= spi.resp[7:0];
          state    <= RD_AZH;
          spi.snd  <= 1'b1;
          spi.cmd  <= 16'hAD00;
        end
        RD_AZH: if (xfer_done) begin
          AZ    <= {spi.resp[7:0], azl_byte};
          vld   <= 1'b1;
          state <= IDLE;
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_sensor_reader.sv
// tb/tb_inert_sensor_reader.sv - directed bench for inert_sensor_reader with an SPI responder model
module tb_inert_sensor_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;

  logic        rsp_done  = 1'b0;
  logic        spur_done = 1'b0;
  logic [15:0] rsp_data  = 16'h0000;
  logic [15:0] pending   = 16'h0000;
  int          rsp_cnt   = 0;
  int          vld_count = 0;
  int          proto_err = 0;
  logic [15:0] cmd_log[$];

  logic [7:0]  tbl_pl, tbl_ph, tbl_azl, tbl_azh;

  int checks = 0;
  int errors = 0;

  inert_sensor_reader_if ifc ();

  assign ifc.done = rsp_done | spur_done;
  assign ifc.resp = rsp_data;

  inert_sensor_reader #(.PWRUP_BITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (INT),
    .spi     (ifc),
    .ptch_rt (ptch_rt),
    .AZ      (AZ),
    .vld     (vld)
  );

  always #5 clk = ~clk;

  // Responder: done 32 clk after snd, upper resp byte is junk the DUT must ignore
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      rsp_cnt  = 0;
      rsp_done = 1'b0;
    end else begin
      rsp_done = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rsp_done = 1'b1;
          case (pending[15:8])
            8'hA2:   rsp_data = {8'hEE, tbl_pl};
            8'hA3:   rsp_data = {8'hEE, tbl_ph};
            8'hAC:   rsp_data = {8'hEE, tbl_azl};
            8'hAD:   rsp_data = {8'hEE, tbl_azh};
            default: rsp_data = 16'hEEFF;
          endcase
        end
      end
      if (ifc.snd) begin
        if (rsp_cnt != 0) proto_err++;
        pending = ifc.cmd;
        rsp_cnt = 32;
        cmd_log.push_back(ifc.cmd);
      end
    end
    if (vld) vld_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic release_and_time(input string tag);
    int n = 0;
    rst_n = 1'b1;
    while (!ifc.snd && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, 16);
  endtask

  task automatic wait_cmds(input string tag, input int n);
    int t = 0;
    while (cmd_log.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(cmd_log.size() >= n), 1);
  endtask

  task automatic wait_vld(input string tag, input int n);
    int t = 0;
    while (vld_count < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(vld_count >= n), 1);
  endtask

  task automatic pulse_int(input int len);
    @(negedge clk);
    INT = 1'b1;
    repeat (len) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic set_tbl(input logic [7:0] a, b, c, d);
    tbl_pl = a; tbl_ph = b; tbl_azl = c; tbl_azh = d;
  endtask

  initial begin
    int base;
    int vcnt;
    rst_n = 1'b0;
    INT   = 1'b0;
    set_tbl(8'h00, 8'h00, 8'h00, 8'h00);

    // 1. reset state, power-up wait, configuration sequence
    repeat (3) @(negedge clk);
    check("rst_snd", 32'(ifc.snd), 0);
    check("rst_cmd", 32'(ifc.cmd), 0);
    check("rst_ptch", 32'(ptch_rt), 0);
    check("rst_az", 32'(AZ), 0);
    check("rst_vld", 32'(vld), 0);
    release_and_time("pwrup_gap");
    wait_cmds("cfg_wait", 4);
    check("cfg0", 32'(cmd_log[0]), 32'h0D02);
    check("cfg1", 32'(cmd_log[1]), 32'h1053);
    check("cfg2", 32'(cmd_log[2]), 32'h1150);
    check("cfg3", 32'(cmd_log[3]), 32'h1460);
    repeat (40) @(negedge clk);
    check("cfg_vld", vld_count, 0);
    check("cfg_ptch", 32'(ptch_rt), 0);
    check("cfg_az", 32'(AZ), 0);

    // 2. basic read with INT latency
    set_tbl(8'h34, 8'h12, 8'h78, 8'h56);
    base = cmd_log.size();
    @(negedge clk);
    INT = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("int_lat_early", 32'(ifc.snd), 0);
    @(posedge clk);
    #1;
    check("int_lat", 32'(ifc.snd), 1);
    repeat (3) @(negedge clk);
    INT = 1'b0;
    wait_vld("rd1_wait", 1);
    check("rd1_ptch", 32'(ptch_rt), 32'h1234);
    check("rd1_az", 32'(AZ), 32'h5678);
    repeat (100) @(negedge clk);
    check("rd1_vld_cnt", vld_count, 1);
    check("rd1_ncmd", cmd_log.size(), base + 4);
    check("rd1_c0", 32'(cmd_log[base]), 32'hA200);
    check("rd1_c1", 32'(cmd_log[base+1]), 32'hA300);
    check("rd1_c2", 32'(cmd_log[base+2]), 32'hAC00);
    check("rd1_c3", 32'(cmd_log[base+3]), 32'hAD00);

    // 3. negative values, hold between strobes
    set_tbl(8'h00, 8'hF0, 8'h00, 8'h80);
    pulse_int(4);
    wait_vld("rd2_wait", 2);
    check("rd2_ptch", 32'(ptch_rt), 32'hF000);
    check("rd2_az", 32'(AZ), 32'h8000);
    repeat (60) @(negedge clk);
    check("hold_ptch", 32'(ptch_rt), 32'hF000);
    check("hold_az", 32'(AZ), 32'h8000);
    check("hold_vld_cnt", vld_count, 2);

    // 6. spurious done in IDLE
    base = cmd_log.size();
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (20) @(negedge clk);
    check("spur_vld_cnt", vld_count, 2);
    check("spur_ncmd", cmd_log.size(), base);
    check("spur_ptch", 32'(ptch_rt), 32'hF000);
    check("spur_az", 32'(AZ), 32'h8000);

    // 4a. INT pulse during RD_PH is ignored
    set_tbl(8'h11, 8'h22, 8'h33, 8'h44);
    base = cmd_log.size();
    pulse_int(4);
    wait_cmds("mid_ph_wait", base + 2);
    pulse_int(4);
    wait_vld("mid_wait", 3);
    repeat (150) @(negedge clk);
    check("mid_vld_cnt", vld_count, 3);
    check("mid_ncmd", cmd_log.size(), base + 4);
    check("mid_ptch", 32'(ptch_rt), 32'h2211);
    check("mid_az", 32'(AZ), 32'h4433);

    // 4b. INT held high: back-to-back sequences; dropping after 2nd strobe still lets the 3rd run
    base = cmd_log.size();
    @(negedge clk);
    INT = 1'b1;
    wait_vld("b2b_wait", 5);
    INT = 1'b0;
    repeat (200) @(negedge clk);
    check("b2b_vld_cnt", vld_count, 6);
    check("b2b_ncmd", cmd_log.size(), base + 12);

    // 5. reset during RD_AZL
    set_tbl(8'h55, 8'h66, 8'h77, 8'h88);
    base = cmd_log.size();
    pulse_int(4);
    wait_cmds("azl_wait", base + 3);
    repeat (5) @(negedge clk);
    check("pre_rst_ptch", 32'(ptch_rt), 32'h6655);
    vcnt = vld_count;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ptch", 32'(ptch_rt), 0);
    check("mid_rst_az", 32'(AZ), 0);
    check("mid_rst_snd", 32'(ifc.snd), 0);
    check("mid_rst_cmd", 32'(ifc.cmd), 0);
    base = cmd_log.size();
    release_and_time("pwrup_gap2");
    wait_cmds("recfg_wait", base + 4);
    check("recfg0", 32'(cmd_log[base]), 32'h0D02);
    check("recfg3", 32'(cmd_log[base+3]), 32'h1460);
    repeat (40) @(negedge clk);
    check("rst_vld_cnt", vld_count, vcnt);
    check("rst_az_after", 32'(AZ), 0);

    check("proto", proto_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
